mtr_step_gen: RTL and testbench

- Stepper-motor step/direction generator directly downstream of the bus control block.
- Consumes that block's mtr_en / mtr_dir / mtr_speed register outputs and drives the external stepper driver's STEP/DIR/EN pins.
- Applies a linear speed ramp, safe direction reversal (decelerate, settle, reverse) and fixed-width step pulses, using a phase-accumulator rate generator.

---
 rtl/mtr_step_gen.sv | 152 +++++++++++++++
 tb/tb_mtr_step_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_step_gen.sv
// mtr_step_gen: stepper-motor STEP/DIR/EN generator.
// Takes the run request, direction and target rate from the bus control block.
// Drives a stepper driver with a linear speed ramp and fixed-width step pulses.
// Step timing comes from a phase accumulator.
// A direction change never happens on the fly: the motor decelerates to zero,
// the new direction is held for DIR_SETUP cycles, then it re-accelerates.
//
// Ports:
//   bus_clk, rst          clock, synchronous active-high reset
//   mtr_en, mtr_dir       run request / requested direction (1 = forward)
//   mtr_speed             target step rate (saturated at SPEED_MAX)
//   drv_step/dir/en       stepper driver pins
//   busy                  controller is not idle
//   at_speed              running at a non-zero effective target
//   pos                   signed step position (only with MTR_STEP_POS_EN)
//
// Optional feature: define MTR_STEP_POS_EN to add the pos step counter.
module mtr_step_gen #(
   parameter int unsigned SPEED_W   = 16,
   parameter int unsigned ACC_W     = 32,
   parameter int unsigned SPEED_MAX = 16'h4000,
   parameter int unsigned ACCEL     = 16,
   parameter int unsigned RAMP_DIV  = 1000,
   parameter int unsigned PULSE_W   = 200,
   parameter int unsigned DIR_SETUP = 500
) (
   input  logic               bus_clk,
   input  logic               rst,
   input  logic               mtr_en,
   input  logic               mtr_dir,
   input  logic [SPEED_W-1:0] mtr_speed,
   output logic               drv_step,
   output logic               drv_dir,
   output logic               drv_en,
   output logic               busy,
   output logic               at_speed
`ifdef MTR_STEP_POS_EN
  ,output logic signed [31:0] pos
`endif
);
   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int PLS_W = $clog2(PULSE_W + 1);
   localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
   localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);
   localparam logic [SPEED_W-1:0] SPD_ACC  = SPEED_W'(ACCEL);
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);
   localparam logic [PLS_W-1:0]   PLS_LOAD = PLS_W'(PULSE_W);
   localparam logic [SET_W-1:0]   SET_LOAD = SET_W'(DIR_SETUP - 1);

   typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
   state_t state, state_nxt;

   logic [SPEED_W-1:0] cur_speed, spd_nxt, tgt;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W:0]     acc_sum;
   logic [DIV_W-1:0]   div_cnt;
   logic [PLS_W-1:0]   pls_cnt;
   logic [SET_W-1:0]   set_cnt;
   logic               ramp_tick, pls_act, carry, pls_start, enter_setup;

   // A request for the opposite direction counts as "stop", which is what
   // drives the decelerate-before-reverse behaviour.
   assign tgt = (mtr_en && (mtr_dir == drv_dir)) ?
                ((mtr_speed > SPD_MAX) ? SPD_MAX : mtr_speed) : '0;

   assign ramp_tick = (div_cnt == DIV_LAST);
   assign pls_act   = (pls_cnt != '0);
   assign acc_sum   = {1'b0, acc} + {{(ACC_W + 1 - SPEED_W){1'b0}}, cur_speed};
   assign carry     = (state == RUN) && (cur_speed != '0) && acc_sum[ACC_W];
   // Carries that land inside an active pulse are dropped.
   assign pls_start = carry && !pls_act;

   assign drv_step = pls_act;
   assign busy     = (state != IDLE);
   assign drv_en   = busy;
   assign at_speed = (state == RUN) && (cur_speed == tgt) && (tgt != '0);

   always_ff @(posedge bus_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      enter_setup = 1'b0;
      case (state)
         IDLE: if (mtr_en) begin
            state_nxt   = SETUP;
            enter_setup = 1'b1;
         end
         SETUP: if (set_cnt == '0) state_nxt = RUN;
         RUN: if ((cur_speed == '0) && !pls_act) begin
            if (!mtr_en) begin
               state_nxt = IDLE;
            end else if (mtr_dir != drv_dir) begin
               state_nxt   = SETUP;
               enter_setup = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ramp one ACCEL step toward tgt per tick; differences are compared first
   // so the result clamps at tgt without overshoot or wrap.
   always_comb begin
      spd_nxt = cur_speed;
      if (state != RUN) begin
         spd_nxt = '0;
      end else if (ramp_tick) begin
         if (cur_speed < tgt)
            spd_nxt = ((tgt - cur_speed) <= SPD_ACC) ? tgt : cur_speed + SPD_ACC;
         else if (cur_speed > tgt)
            spd_nxt = ((cur_speed - tgt) <= SPD_ACC) ? tgt : cur_speed - SPD_ACC;
      end
   end

   always_ff @(posedge bus_clk) begin
      if (rst) begin
         cur_speed <= '0;
         acc       <= '0;
         div_cnt   <= '0;
         pls_cnt   <= '0;
         set_cnt   <= '0;
         drv_dir   <= 1'b0;
      end else begin
         cur_speed <= spd_nxt;
         div_cnt   <= ramp_tick ? '0 : div_cnt + 1'b1;
         // drv_dir only changes here, and entry to SETUP is only possible
         // with zero speed and no pulse in flight.
         if (enter_setup) begin
            drv_dir <= mtr_dir;
            acc     <= '0;
            set_cnt <= SET_LOAD;
         end else begin
            if ((state == RUN) && (cur_speed != '0)) acc <= acc_sum[ACC_W-1:0];
            if ((state == SETUP) && (set_cnt != '0)) set_cnt <= set_cnt - 1'b1;
         end
         if (pls_start)    pls_cnt <= PLS_LOAD;
         else if (pls_act) pls_cnt <= pls_cnt - 1'b1;
      end
   end

`ifdef MTR_STEP_POS_EN
   // Position survives IDLE; only reset clears it.
   always_ff @(posedge bus_clk) begin
      if (rst)            pos <= '0;
      else if (pls_start) pos <= drv_dir ? pos + 32'sd1 : pos - 32'sd1;
   end
`endif

endmodule

// File: tb/tb_mtr_step_gen.sv
module tb_mtr_step_gen;
   localparam int SPEED_W   = 16;
   localparam int ACC_W     = 16;
   localparam int SPEED_MAX = 'h0800;
   localparam int ACCEL     = 8;
   localparam int RAMP_DIV  = 4;
   localparam int PULSE_W   = 4;
   localparam int DIR_SETUP = 10;
   localparam int PHASE_MOD = 1 << ACC_W;
   localparam int M_IDLE = 0, M_SETUP = 1, M_RUN = 2;

   logic               bus_clk = 1'b0;
   logic               rst = 1'b1;
   logic               mtr_en = 1'b1;
   logic               mtr_dir = 1'b1;
   logic [SPEED_W-1:0] mtr_speed = 16'h0100;
   logic               drv_step, drv_dir, drv_en, busy, at_speed;
`ifdef MTR_STEP_POS_EN
   logic signed [31:0] pos;
`endif

   mtr_step_gen #(
      .SPEED_W(SPEED_W), .ACC_W(ACC_W), .SPEED_MAX(SPEED_MAX), .ACCEL(ACCEL),
      .RAMP_DIV(RAMP_DIV), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
   ) dut (
      .bus_clk(bus_clk), .rst(rst), .mtr_en(mtr_en), .mtr_dir(mtr_dir),
      .mtr_speed(mtr_speed), .drv_step(drv_step), .drv_dir(drv_dir),
      .drv_en(drv_en), .busy(busy), .at_speed(at_speed)
`ifdef MTR_STEP_POS_EN
     ,.pos(pos)
`endif
   );

   always #5 bus_clk = ~bus_clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   bit mdl_on = 0;
   bit wmon_on = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge bus_clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   int m_mode = M_IDLE, m_speed = 0, m_phase = 0, m_div = 0, m_pl = 0, m_sl = 0;
   bit m_dir = 0;
   logic signed [31:0] m_pos = 0;

   function automatic int min_i(input int a, input int b); return (a < b) ? a : b; endfunction
   function automatic int max_i(input int a, input int b); return (a > b) ? a : b; endfunction

   function automatic int mdl_tgt(input bit en, input bit dir, input int spd, input bit mdir);
      return (en && dir == mdir) ? min_i(spd, SPEED_MAX) : 0;
   endfunction

   always @(posedge bus_clk) begin : mdl
      int t, old_mode, pl_n;
      bit tick, carry;
      if (rst) begin
         m_mode = M_IDLE; m_speed = 0; m_phase = 0; m_div = 0;
         m_pl = 0; m_sl = 0; m_dir = 0; m_pos = 0;
      end else begin
         old_mode = m_mode;
         t = mdl_tgt(mtr_en, mtr_dir, int'(mtr_speed), m_dir);
         tick = (m_div == RAMP_DIV - 1);
         m_div = tick ? 0 : m_div + 1;
         carry = 0;
         if (old_mode == M_RUN && m_speed != 0) begin
            m_phase = m_phase + m_speed;
            if (m_phase >= PHASE_MOD) begin
               m_phase = m_phase - PHASE_MOD;
               carry = 1;
            end
         end
         pl_n = (m_pl > 0) ? m_pl - 1 : 0;
         if (carry && m_pl == 0) begin
            pl_n = PULSE_W;
            m_pos = m_dir ? m_pos + 32'sd1 : m_pos - 32'sd1;
         end
         case (old_mode)
            M_IDLE: if (mtr_en) begin
               m_mode = M_SETUP; m_dir = mtr_dir; m_phase = 0; m_sl = DIR_SETUP;
            end
            M_SETUP: begin
               m_sl = m_sl - 1;
               if (m_sl == 0) m_mode = M_RUN;
            end
            default: if (m_speed == 0 && m_pl == 0) begin
               if (!mtr_en) m_mode = M_IDLE;
               else if (mtr_dir != m_dir) begin
                  m_mode = M_SETUP; m_dir = mtr_dir; m_phase = 0; m_sl = DIR_SETUP;
               end
            end
         endcase
         if (old_mode != M_RUN) m_speed = 0;
         else if (tick)
            m_speed = (m_speed < t) ? min_i(m_speed + ACCEL, t) : max_i(m_speed - ACCEL, t);
         m_pl = pl_n;
      end
   end

   always @(negedge bus_clk) begin : mdl_cmp
      int t;
      bit e_run;
      if (mdl_on) begin
         t = mdl_tgt(mtr_en, mtr_dir, int'(mtr_speed), m_dir);
         e_run = (m_mode != M_IDLE);
         chk("mdl_outs", 64'({drv_step, drv_dir, drv_en, busy, at_speed}),
             64'({m_pl > 0, m_dir, e_run, e_run,
                  (m_mode == M_RUN) && (m_speed == t) && (t != 0)}));
`ifdef MTR_STEP_POS_EN
         chk("mdl_pos", 64'(pos), 64'(m_pos));
`endif
      end
   end

   // Pulse-width and step-direction monitor.
   int run_len = 0;
   int n_fwd = 0, n_rev = 0;
   always @(negedge bus_clk) begin
      if (drv_step) begin
         if (run_len == 0) begin
            if (drv_dir) n_fwd++;
            else         n_rev++;
         end
         run_len++;
      end else begin
         if (run_len > 0 && wmon_on) chk("pulse_w", 64'(run_len), 64'(PULSE_W));
         run_len = 0;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_rise(input int bound, output int t, output bit ok);
      int n;
      n = 0;
      while (drv_step && n < bound) begin @(negedge bus_clk); n++; end
      while (!drv_step && n < bound) begin @(negedge bus_clk); n++; end
      ok = drv_step;
      t = cyc;
   endtask

   task automatic pulse_w(output int w);
      w = 0;
      while (drv_step && w < 50) begin w++; @(negedge bus_clk); end
   endtask

   task automatic wait_at_speed(input string tag, input int bound);
      int n;
      n = 0;
      while (!at_speed && n < bound) begin @(negedge bus_clk); n++; end
      chk(tag, 64'(at_speed), 64'd1);
   endtask

   initial begin
      int n, c0, t1, t2, w, p, q;
      bit ok, seen;
`ifdef MTR_STEP_POS_EN
      logic signed [31:0] p0;
      int f0, r0;
`endif
      // Reset with run request already asserted.
      @(posedge bus_clk);
      mdl_on = 1;
      repeat (2) @(posedge bus_clk);
      @(negedge bus_clk);
      chk("rst_outs", 64'({drv_step, drv_dir, drv_en, busy, at_speed}), 64'd0);
`ifdef MTR_STEP_POS_EN
      chk("rst_pos", 64'(pos), 64'd0);
`endif
      rst = 0;
      @(negedge bus_clk);
      chk("start_busy", 64'({busy, drv_en, drv_dir}), 64'b111);
      c0 = cyc;
      seen = 0;
      repeat (DIR_SETUP) begin seen |= drv_step; @(negedge bus_clk); end
      chk("setup_nostep", 64'(seen), 64'd0);
      wait_at_speed("at_speed_0100", 400);
      chk("ramp_time_0100", 64'((cyc - c0) >= 135 && (cyc - c0) <= 138), 64'd1);
      wait_rise(600, t1, ok);
      wait_rise(600, t2, ok);
      chk("rise_0100", 64'(ok), 64'd1);
      chk("period_0100", 64'(t2 - t1), 64'd256);
      pulse_w(w);
      chk("width_0100", 64'(w), 64'(PULSE_W));
      wmon_on = 1;

      // Saturation at SPEED_MAX.
      mtr_speed = 16'hFFFF;
      @(negedge bus_clk);
      wait_at_speed("at_speed_sat", 1500);
      wait_rise(100, t1, ok);
      wait_rise(100, t2, ok);
      chk("rise_sat", 64'(ok), 64'd1);
      chk("period_sat", 64'(t2 - t1), 64'd32);

      // Back down, then reverse.
      mtr_speed = 16'h0100;
      @(negedge bus_clk);
      wait_at_speed("at_speed_back", 1500);
      mtr_dir = 0;
      n = 0;
      while (drv_dir && n < 800) begin @(negedge bus_clk); n++; end
      chk("rev_dir", 64'(drv_dir), 64'd0);
      chk("rev_flip_state", 64'({drv_step, busy}), 64'b01);
      seen = 0;
      repeat (DIR_SETUP) begin seen |= drv_step; @(negedge bus_clk); end
      chk("rev_setup_nostep", 64'(seen), 64'd0);
      wait_rise(1000, t1, ok);
      chk("rev_reaccel", 64'({ok, drv_dir}), 64'b10);
      wait_at_speed("at_speed_rev", 600);

      // Drop the run request in the middle of a pulse.
      wait_rise(600, t1, ok);
      chk("drop_rise", 64'(ok), 64'd1);
      @(negedge bus_clk);
      mtr_en = 0;
      p = cyc;
      pulse_w(w);
      chk("drop_pulse_w", 64'(w + 1), 64'(PULSE_W));
      n = 0;
      while (busy && n < 400) begin @(negedge bus_clk); n++; end
      q = cyc;
      chk("drop_idle", 64'({busy, drv_en}), 64'd0);
      chk("drop_decel_time", 64'((q - p) >= 126 && (q - p) <= 133), 64'd1);

`ifdef MTR_STEP_POS_EN
      // Forward steps, then reverse steps; pos tracks the net count.
      repeat (3) @(negedge bus_clk);
      p0 = pos; f0 = n_fwd; r0 = n_rev;
      mtr_dir = 1; mtr_speed = 16'h0800; mtr_en = 1;
      n = 0;
      while (n_fwd - f0 < 10 && n < 3000) begin @(negedge bus_clk); n++; end
      mtr_dir = 0;
      n = 0;
      while (n_rev - r0 < 3 && n < 5000) begin @(negedge bus_clk); n++; end
      mtr_en = 0;
      n = 0;
      while (busy && n < 3000) begin @(negedge bus_clk); n++; end
      repeat (2) @(negedge bus_clk);
      chk("pos_fwd_cnt", 64'(n_fwd - f0 >= 10), 64'd1);
      chk("pos_rev_cnt", 64'(n_rev - r0 >= 3), 64'd1);
      chk("pos_net", 64'(pos - p0), 64'((n_fwd - f0) - (n_rev - r0)));
`endif

      // Random stimulus against the model; resets may truncate pulses.
      wmon_on = 0;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 99) < 8) begin
            rst = 1;
            repeat ($urandom_range(1, 3)) @(negedge bus_clk);
            rst = 0;
         end
         mtr_en  = ($urandom_range(0, 3) != 0);
         mtr_dir = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       mtr_speed = 16'hFFFF;
            1:       mtr_speed = 16'($urandom_range(0, 8) * 8);
            2:       mtr_speed = 16'($urandom_range(0, 'h0FFF));
            default: mtr_speed = 16'($urandom_range('h0100, 'h0900));
         endcase
         repeat ($urandom_range(10, 600)) @(negedge bus_clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
